// File: rtl/qdivs_seq_if.sv
// rtl/qdivs_seq_if.sv - start/busy/done handshake and operand/result bundle for qdivs_seq
//   start, a (divisor), b (dividend)      : requester -> divider
//   busy, done, y (quotient), div_zero    : divider -> requester
interface qdivs_seq_if #(
    parameter int N = 24
);
    logic         start;
    logic [7:0]   a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] y;
    logic         div_zero;

    modport master (output start, a, b, input busy, done, y, div_zero);
    modport slave  (input start, a, b, output busy, done, y, div_zero);
endinterface

// File: rtl/qdivs_seq.sv
// rtl/qdivs_seq.sv - sequential restoring divider, signed-magnitude Q dividend by 8-bit unsigned divisor
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   bus    : qdivs_seq_if.slave (start, a, b in; busy, done, y, div_zero out)
//   Optional macro QDIVS_ROUND_EN: round half away from zero, one extra ROUND cycle.
module qdivs_seq #(
    parameter int N = 24,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         resetn,
    qdivs_seq_if.slave   bus
);
    localparam int CW = $clog2(N);

    // Q does not change the arithmetic: input and output share the format.
    if (Q < 0 || Q > N - 1) begin : g_bad_q
        $error("qdivs_seq: Q must lie in 0..N-1");
    end

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND} state_t;

    state_t        state_q, state_d;
    logic          sign_q, sign_d;
    logic [7:0]    div_q, div_d;
    logic [N-2:0]  quot_q, quot_d;
    logic [8:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  y_q, y_d;
    logic          dz_q, dz_d;

    logic [9:0]    t;
    logic          t_ge;
    logic [8:0]    rem_step;
    logic [N-2:0]  quot_step;
    logic          fin;
    logic [N-2:0]  fin_mag;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        dz_d    = dz_q;
        fin     = 1'b0;
        fin_mag = quot_q;

        // One restoring step: bring the next dividend bit into the remainder.
        t         = {rem_q, quot_q[N-2]};
        t_ge      = (t >= {2'b00, div_q});
        rem_step  = t_ge ? 9'(t - {2'b00, div_q}) : t[8:0];
        quot_step = {quot_q[N-3:0], t_ge};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.a != 8'd0) begin
                        sign_d  = bus.b[N-1];
                        div_d   = bus.a;
                        quot_d  = bus.b[N-2:0];
                        rem_d   = 9'd0;
                        cnt_d   = CW'(N - 1);
                        busy_d  = 1'b1;
                        state_d = S_DIV;
                    end else begin
                        // Divide by zero completes on the accepting edge.
                        y_d    = {bus.b[N-1], {(N-1){1'b1}}};
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                quot_d = quot_step;
                rem_d  = rem_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef QDIVS_ROUND_EN
                    state_d = S_ROUND;
`else
                    fin     = 1'b1;
                    fin_mag = quot_step;
`endif
                end
            end
            S_ROUND: begin
`ifdef QDIVS_ROUND_EN
                fin = 1'b1;
                // Half or more of the divisor left over rounds up; never wrap past all ones.
                if (({rem_q, 1'b0} >= {2'b00, div_q}) && !(&quot_q)) begin
                    fin_mag = quot_q + (N-1)'(1);
                end
`else
                state_d = S_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (fin) begin
            // A zero magnitude is always reported as +0.
            y_d     = (fin_mag == '0) ? '0 : {sign_q, fin_mag};
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            div_q   <= 8'd0;
            quot_q  <= '0;
            rem_q   <= 9'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.y        = y_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_qdivs_seq.sv
// tb/tb_qdivs_seq.sv - self-checking bench for qdivs_seq
module tb_qdivs_seq;
    localparam int N = 24;
`ifdef QDIVS_ROUND_EN
    localparam int LAT = N;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = N - 1;
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    qdivs_seq_if #(.N(N)) bus ();

    qdivs_seq #(.N(N), .Q(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]   a;
        logic [N-1:0] b;
        logic [N-1:0] y_trunc;
        logic [N-1:0] y_round;
        logic         dz;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge.
    task automatic start_op(input logic [7:0] av, input logic [N-1:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered at the negedge right after the accepting edge (m = 0).
    task automatic wait_done(input string name, input int lat, input logic [N-1:0] ey, input logic edz);
        int m = 0;
        int busy_cnt = 0;
        while (!bus.done && m < 200) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            m++;
        end
        check({name, " latency"}, 32'(m), 32'(lat));
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({name, " y"}, 32'(bus.y), 32'(ey));
        check({name, " div_zero"}, 32'(bus.div_zero), 32'(edz));
        check({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = '0;

        vecs[0]  = '{8'd2,   24'h018000, 24'h00C000, 24'h00C000, 1'b0};
        vecs[1]  = '{8'd3,   24'h818000, 24'h808000, 24'h808000, 1'b0};
        vecs[2]  = '{8'd5,   24'h800001, 24'h000000, 24'h000000, 1'b0};
        vecs[3]  = '{8'd2,   24'h000005, 24'h000002, 24'h000003, 1'b0};
        vecs[4]  = '{8'd0,   24'h818000, 24'hFFFFFF, 24'hFFFFFF, 1'b1};
        vecs[5]  = '{8'd1,   24'h010000, 24'h010000, 24'h010000, 1'b0};
        vecs[6]  = '{8'd255, 24'h7FFFFF, 24'h008080, 24'h008080, 1'b0};
        vecs[7]  = '{8'd2,   24'hFFFFFF, 24'hBFFFFF, 24'hC00000, 1'b0};
        vecs[8]  = '{8'd3,   24'h000007, 24'h000002, 24'h000002, 1'b0};
        vecs[9]  = '{8'd3,   24'h800002, 24'h000000, 24'h800001, 1'b0};
        vecs[10] = '{8'd7,   24'h000000, 24'h000000, 24'h000000, 1'b0};
        vecs[11] = '{8'd0,   24'h012345, 24'h7FFFFF, 24'h7FFFFF, 1'b1};

        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset y", 32'(bus.y), 32'd0);
        check("reset div_zero", 32'(bus.div_zero), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_op(vecs[i].a, vecs[i].b);
            check({nm, " busy_after_accept"}, 32'(bus.busy), 32'(!vecs[i].dz));
            wait_done(nm, vecs[i].dz ? 0 : LAT, RND ? vecs[i].y_round : vecs[i].y_trunc, vecs[i].dz);
            @(negedge clk);
            check({nm, " done_pulse_end"}, 32'(bus.done), 32'd0);
            check({nm, " y_hold"}, 32'(bus.y), 32'(RND ? vecs[i].y_round : vecs[i].y_trunc));
        end

        // Starts while busy are ignored; start held in the done cycle is accepted next edge.
        begin
            int m = 0;
            start_op(8'd1, 24'h7FFFFF);
            while (!bus.done && m < 200) begin
                @(negedge clk);
                m++;
                if (m == 5 || m == 10) begin
                    bus.start = 1'b1;
                    bus.a     = 8'd3;
                    bus.b     = 24'h000009;
                end else begin
                    bus.start = 1'b0;
                end
            end
            bus.start = 1'b0;
            check("ignore latency", 32'(m), 32'(LAT));
            check("ignore y", 32'(bus.y), 32'h7FFFFF);
            start_op(8'd3, 24'h000009);
            check("b2b busy_after_accept", 32'(bus.busy), 32'd1);
            wait_done("b2b", LAT, 24'h000003, 1'b0);
        end

        // Reset in the middle of an operation.
        @(negedge clk);
        start_op(8'd2, 24'h018000);
        repeat (9) @(negedge clk);
        check("pre_reset busy", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset y", 32'(bus.y), 32'd0);
        check("midreset div_zero", 32'(bus.div_zero), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("in_reset done", 32'(bus.done), 32'd0);
        end
        resetn = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check("post_reset no_done", 32'(bus.done), 32'd0);
        end
        start_op(8'd3, 24'h818000);
        wait_done("after_reset", LAT, 24'h808000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
